// File: rtl/mem_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_stall_ctrl
// Description : MEM-stage data-memory access controller. It holds the
//               pipeline while a variable-latency data memory completes a load
//               or store, bounds each wait with a timeout, and presents the
//               load result to the MEM/WB register for exactly one cycle.
// Revision    : 1.0  initial release
// ============================================================================
module mem_stall_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        mem_ready_i,
    input  logic [31:0] mem_rdata_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [31:0] dmem_rdata_o,
    output logic        stall_o,
    output logic        bubble_o,
    output logic        timeout_o
);

    localparam logic [1:0]  c_IDLE     = 2'd0;
    localparam logic [1:0]  c_BUSY     = 2'd1;
    localparam logic [1:0]  c_DONE     = 2'd2;
    // Last wait-counter value before the access is abandoned.
    localparam logic [7:0]  c_TO_LAST  = 8'(TIMEOUT - 1);
    localparam logic [31:0] c_BAD_DATA = 32'hDEADBEEF;

    logic [1:0]  r_state;
    logic [7:0]  r_cnt;
    logic        r_req;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_timeout;

    logic        w_access;
    logic        w_stall;

    assign w_access = MemRead_i | MemWrite_i;

    // Stall covers the detect cycle in IDLE and every cycle spent waiting.
    always_comb begin
        w_stall = ((r_state == c_IDLE) & w_access) | (r_state == c_BUSY);
    end

    // Access sequencing: latch the request, wait for ready or timeout, then
    // spend one DONE cycle so MEM/WB captures the finished instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_cnt     <= 8'd0;
            r_req     <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= 32'd0;
            r_wdata   <= 32'd0;
            r_rdata   <= 32'd0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_access) begin
                        r_state <= c_BUSY;
                        r_req   <= 1'b1;
                        r_addr  <= addr_i;
                        r_wdata <= wdata_i;
                        // A simultaneous read and write is handled as a store.
                        r_we    <= MemWrite_i;
                        r_cnt   <= 8'd0;
                    end
                end
                c_BUSY: begin
                    if (mem_ready_i) begin
                        // Ready wins over a coinciding timeout.
                        r_state <= c_DONE;
                        r_req   <= 1'b0;
                        if (!r_we) begin
                            r_rdata <= mem_rdata_i;
                        end
                    end else if (r_cnt == c_TO_LAST) begin
                        r_state   <= c_DONE;
                        r_req     <= 1'b0;
                        r_timeout <= 1'b1;
                        if (!r_we) begin
                            r_rdata <= c_BAD_DATA;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                c_DONE: begin
                    // The memory controls still belong to the completed
                    // instruction here, so they are not looked at.
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req_o    = r_req;
    assign mem_we_o     = r_we;
    assign mem_addr_o   = r_addr;
    assign mem_wdata_o  = r_wdata;
    assign dmem_rdata_o = r_rdata;
    assign timeout_o    = r_timeout;
    assign stall_o      = w_stall;
    assign bubble_o     = w_stall;

endmodule
`default_nettype wire

// File: tb/tb_mem_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stall_ctrl
// Description : Self-checking bench for mem_stall_ctrl with a transaction
//               level reference model, directed scenarios and random traffic.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mem_stall_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd, wr, rdy;
    logic [31:0] addr, wdata, rdata_in;
    logic        req, we, stall, bubble, tout;
    logic [31:0] maddr, mwdata, drdata;

    int n_tests = 0;
    int n_fail  = 0;
    bit check_en = 1'b0;

    mem_stall_ctrl #(.TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .MemRead_i    (rd),
        .MemWrite_i   (wr),
        .addr_i       (addr),
        .wdata_i      (wdata),
        .mem_ready_i  (rdy),
        .mem_rdata_i  (rdata_in),
        .mem_req_o    (req),
        .mem_we_o     (we),
        .mem_addr_o   (maddr),
        .mem_wdata_o  (mwdata),
        .dmem_rdata_o (drdata),
        .stall_o      (stall),
        .bubble_o     (bubble),
        .timeout_o    (tout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    // An access is either in flight (waiting for memory, m_wait cycles so
    // far) or just finished (one completion cycle), or there is none.
    bit          m_inflight = 0;
    bit          m_finished = 0;
    int          m_wait     = 0;
    bit          m_we       = 0;
    logic [31:0] m_addr     = 0;
    logic [31:0] m_wdata    = 0;
    logic [31:0] m_rdata    = 0;
    bit          m_to       = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_inflight = 0; m_finished = 0; m_wait = 0; m_we = 0;
            m_addr = 0; m_wdata = 0; m_rdata = 0; m_to = 0;
        end else if (m_inflight) begin
            m_wait = m_wait + 1;
            if (rdy) begin
                m_inflight = 0; m_finished = 1;
                if (!m_we) m_rdata = rdata_in;
            end else if (m_wait == TO) begin
                m_inflight = 0; m_finished = 1; m_to = 1;
                if (!m_we) m_rdata = 32'hDEADBEEF;
            end
        end else if (m_finished) begin
            m_finished = 0;
        end else if (rd || wr) begin
            m_inflight = 1; m_wait = 0;
            m_we = wr; m_addr = addr; m_wdata = wdata;
        end
    end

    // Every cycle: DUT outputs against the model.
    always @(negedge clk) begin
        if (check_en) begin
            logic exp_stall;
            exp_stall = m_inflight || (!m_finished && (rd || wr));
            chk("stall",   {31'd0, stall},  {31'd0, exp_stall});
            chk("bubble",  {31'd0, bubble}, {31'd0, exp_stall});
            chk("req",     {31'd0, req},    {31'd0, m_inflight});
            chk("we",      {31'd0, we},     {31'd0, m_we});
            chk("addr",    maddr,  m_addr);
            chk("wdata",   mwdata, m_wdata);
            chk("rdata",   drdata, m_rdata);
            chk("timeout", {31'd0, tout},   {31'd0, m_to});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Run one access; ready_at = index of the BUSY cycle (1-based) in which
    // memory answers, or 0 for never. Returns at the negedge of the first
    // non-stalled cycle with the number of stalled cycles seen.
    task automatic access(input bit r, input bit w, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] rdv,
                          input int ready_at, output int nstall);
        nstall = 0;
        rd = r; wr = w; addr = a; wdata = d; rdata_in = rdv;
        for (int k = 0; k < 40; k++) begin
            rdy = (ready_at != 0) && (k == ready_at);
            @(negedge clk);
            if (!stall) break;
            nstall++;
            if (k >= 1) begin
                chk("busy_addr",  maddr,  a);
                chk("busy_wdata", mwdata, d);
                chk("busy_we",    {31'd0, we}, {31'd0, w});
            end
            step();
        end
        rdy = 1'b0;
    endtask

    int ns;

    initial begin
        rst = 1'b1; rd = 0; wr = 0; rdy = 0;
        addr = 0; wdata = 0; rdata_in = 0;
        step(); step();
        check_en = 1'b1;
        @(negedge clk);
        chk("reset_req",   {31'd0, req}, 32'd0);
        chk("reset_rdata", drdata, 32'd0);
        chk("reset_to",    {31'd0, tout}, 32'd0);
        step();
        rst = 1'b0;
        step();

        // Single-cycle load.
        access(1, 0, 32'h10, 32'h0, 32'h12345678, 1, ns);
        chk("load_stall_cycles", ns, 2);
        chk("load_done_rdata", drdata, 32'h12345678);
        chk("load_done_stall", {31'd0, stall}, 32'd0);
        step();
        rd = 0;
        step();

        // Store answered in the third BUSY cycle; load data untouched.
        access(0, 1, 32'h20, 32'hCAFEF00D, 32'h55555555, 3, ns);
        chk("store_stall_cycles", ns, 4);
        chk("store_done_rdata", drdata, 32'h12345678);
        step();
        wr = 0;
        step();

        // Ready on the last allowed BUSY cycle: normal completion.
        access(1, 0, 32'h30, 32'h0, 32'hA5A5A5A5, TO, ns);
        chk("late_ready_stall", ns, TO + 1);
        chk("late_ready_rdata", drdata, 32'hA5A5A5A5);
        chk("late_ready_to", {31'd0, tout}, 32'd0);
        step();
        rd = 0;
        step();

        // Load that times out; flag is sticky.
        access(1, 0, 32'h40, 32'h0, 32'h11111111, 0, ns);
        chk("timeout_stall", ns, TO + 1);
        chk("timeout_rdata", drdata, 32'hDEADBEEF);
        chk("timeout_flag", {31'd0, tout}, 32'd1);
        step();
        rd = 0;
        for (int i = 0; i < 10; i++) step();
        @(negedge clk);
        chk("timeout_sticky", {31'd0, tout}, 32'd1);
        step();

        // Back-to-back loads with MemRead held through DONE.
        rst = 1'b1; step(); rst = 1'b0;
        rd = 1; addr = 32'h50; rdata_in = 32'h00000001; rdy = 1;
        begin
            int dones = 0;
            int busy  = 0;
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                if (req) busy++;
                if (!stall) dones++;
                step();
            end
            // Pattern repeats every 3 cycles: detect, BUSY, DONE.
            chk("b2b_busy_cycles", busy, 4);
            chk("b2b_done_cycles", dones, 4);
        end
        rd = 0; rdy = 0;
        step(); step();

        // Reset in the second BUSY cycle abandons the access.
        rd = 1; addr = 32'h60; wdata = 32'h77; rdy = 0;
        step();          // now BUSY 1
        step();          // now BUSY 2
        rst = 1'b1;
        step();
        rst = 1'b0; rd = 0; rdy = 1; rdata_in = 32'hFFFFFFFF;
        @(negedge clk);
        chk("rst_busy_req",   {31'd0, req}, 32'd0);
        chk("rst_busy_addr",  maddr, 32'd0);
        chk("rst_busy_stall", {31'd0, stall}, 32'd0);
        step();
        rdy = 0;
        @(negedge clk);
        chk("rst_busy_rdata", drdata, 32'd0);
        step();

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom_range(0, 79) == 0);
            rd       = ($urandom_range(0, 2) == 0);
            wr       = ($urandom_range(0, 3) == 0);
            rdy      = ($urandom_range(0, 3) == 0);
            addr     = $urandom;
            wdata    = $urandom;
            rdata_in = $urandom;
            step();
        end

        rst = 0; rd = 0; wr = 0; rdy = 0;
        step();
        @(negedge clk);
        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
